// File: rtl/bus_op_queue.sv
// bus_op_queue: buffers L2 bus operations (R/W/M/I) in a FIFO and issues them on a valid/ready bus
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         producer handshake; req_op (2b) and req_addr carry the operation
//   flush                       drop every queued operation not yet handshaken
//   bus_valid/bus_ready         consumer handshake; bus_op and bus_addr present the head entry
//   occupancy                   entries held, including the presented head
//   cnt_read..cnt_inval         saturating counts of issued operations per opcode
//
// Optional macro BUS_TRACE_EN: prints one "<letter> <hex addr>" line per issued operation (simulation only).
module bus_op_queue #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     flush,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [1:0]               bus_op,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         cnt_read,
    output logic [CNT_W-1:0]         cnt_write,
    output logic [CNT_W-1:0]         cnt_modify,
    output logic [CNT_W-1:0]         cnt_inval
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [ADDR_W+1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;
    logic [CNT_W-1:0]  cnt [4];
    logic              push, pop, keep;

    assign bus_valid  = count != '0;
    assign req_ready  = count != FULL && !flush && !reset;
    assign push       = req_valid && req_ready;
    assign pop        = bus_valid && bus_ready;
    // a presented but stalled head must survive a flush so the bus sees a stable operation
    assign keep       = bus_valid && !bus_ready;
    assign {bus_op, bus_addr} = bus_valid ? mem[rd_ptr] : '0;
    assign occupancy  = count;
    assign cnt_read   = cnt[0];
    assign cnt_write  = cnt[1];
    assign cnt_modify = cnt[2];
    assign cnt_inval  = cnt[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            // on flush the write pointer lands right after the head (kept or popped) or on it (empty)
            if (flush) begin
                wr_ptr <= rd_ptr + PW'(bus_valid);
                count  <= (PW+1)'(keep);
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
            for (int i = 0; i < 4; i++)
                if (pop && bus_op == 2'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {req_op, req_addr};

`ifdef BUS_TRACE_EN
    logic [7:0] op_chr;
    assign op_chr = bus_op == 2'd0 ? "R" : bus_op == 2'd1 ? "W" : bus_op == 2'd2 ? "M" : "I";
    always @(posedge clk)
        if (!reset && pop) $display("%c %h", op_chr, bus_addr);
`else
    // tracing disabled: no simulation output
`endif
endmodule

// File: tb/tb_bus_op_queue.sv
// tb_bus_op_queue: directed bench for bus_op_queue with a queue-based reference model
module tb_bus_op_queue;
    localparam int AW = 32, D = 8, CW = 4, SAT = 15;

    logic           clk = 0, reset = 1, req_valid = 0, flush = 0, bus_ready = 0;
    logic           req_ready, bus_valid;
    logic [1:0]     req_op = 0, bus_op;
    logic [AW-1:0]  req_addr = 0, bus_addr;
    logic [3:0]     occupancy;
    logic [CW-1:0]  cnt_read, cnt_write, cnt_modify, cnt_inval;

    bus_op_queue #(.ADDR_W(AW), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .flush(flush), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .bus_op(bus_op), .bus_addr(bus_addr), .occupancy(occupancy),
        .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_modify(cnt_modify), .cnt_inval(cnt_inval)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: an ordered list of pending operations plus per-opcode totals
    typedef struct { logic [1:0] op; logic [AW-1:0] addr; } ent_t;
    ent_t q[$];
    ent_t head;
    int   mcnt[4];
    bit   m_pop;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            for (int i = 0; i < 4; i++) mcnt[i] = 0;
        end else begin
            m_pop = q.size() != 0 && bus_ready;
            if (m_pop) begin
                if (mcnt[q[0].op] < SAT) mcnt[q[0].op]++;
                void'(q.pop_front());
            end
            if (flush) begin
                if (q.size() != 0 && !m_pop) begin
                    head = q[0];
                    q.delete();
                    q.push_back(head);
                end else q.delete();
            end else if (req_valid && q.size() + (m_pop ? 1 : 0) < D)
                q.push_back('{req_op, req_addr});
        end
    end

    always @(posedge clk) begin
        #1;
        chk("bus_valid", bus_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("bus_op", bus_op, q[0].op);
            chk("bus_addr", bus_addr, q[0].addr);
        end
        chk("occupancy", occupancy, q.size());
        chk("req_ready", req_ready, q.size() < D && !flush && !reset);
        chk("cnt_read", cnt_read, mcnt[0]);
        chk("cnt_write", cnt_write, mcnt[1]);
        chk("cnt_modify", cnt_modify, mcnt[2]);
        chk("cnt_inval", cnt_inval, mcnt[3]);
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_op", bus_op, 0);
        reset = 0;
        // single read
        req_valid = 1; req_op = 0; req_addr = 32'h0000A4C0; bus_ready = 1;
        cyc;
        req_valid = 0;
        chk("t1_valid", bus_valid, 1);
        chk("t1_op", bus_op, 0);
        chk("t1_addr", bus_addr, 32'h0000A4C0);
        cyc;
        chk("t1_cnt_read", cnt_read, 1);
        chk("t1_occ", occupancy, 0);
        // ordered W, M, I
        bus_ready = 0; req_valid = 1;
        for (int i = 0; i < 3; i++) begin
            req_op = 2'(i + 1); req_addr = 32'((i + 1) * 'h100);
            cyc;
        end
        req_valid = 0;
        chk("t2_occ", occupancy, 3);
        chk("t2_addr0", bus_addr, 32'h100);
        bus_ready = 1;
        cyc;
        chk("t2_addr1", bus_addr, 32'h200);
        chk("t2_op1", bus_op, 2);
        cyc;
        chk("t2_addr2", bus_addr, 32'h300);
        chk("t2_op2", bus_op, 3);
        cyc;
        chk("t2_occ_end", occupancy, 0);
        chk("t2_cw", cnt_write, 1);
        chk("t2_cm", cnt_modify, 1);
        chk("t2_ci", cnt_inval, 1);
        // fill to full, push refused during a pop
        bus_ready = 0; req_valid = 1;
        for (int i = 0; i < D; i++) begin
            req_op = 2'(i); req_addr = 32'h1000 + 32'(i);
            cyc;
        end
        chk("t3_occ_full", occupancy, 8);
        chk("t3_ready_full", req_ready, 0);
        req_addr = 32'h2000; bus_ready = 1;
        cyc;
        chk("t3_occ_after", occupancy, 7);
        chk("t3_ready_after", req_ready, 1);
        req_valid = 0;
        cyc(2);
        bus_ready = 0;
        chk("t4_occ5", occupancy, 5);
        chk("t4_head", bus_addr, 32'h1003);
        // flush with a stalled head
        flush = 1;
        cyc;
        flush = 0;
        chk("t4_occ1", occupancy, 1);
        chk("t4_head_kept", bus_addr, 32'h1003);
        chk("t4_valid", bus_valid, 1);
        bus_ready = 1;
        cyc;
        chk("t4_occ0", occupancy, 0);
        chk("t4_ci", cnt_inval, 2);
        // flush coinciding with a pop
        bus_ready = 0; req_valid = 1; req_op = 1; req_addr = 32'h500;
        cyc;
        req_addr = 32'h600;
        cyc;
        req_valid = 0; bus_ready = 1; flush = 1;
        cyc;
        flush = 0; bus_ready = 0;
        chk("t5_occ", occupancy, 0);
        chk("t5_cw", cnt_write, 3);
        // saturation
        req_valid = 1; req_op = 0; bus_ready = 1;
        for (int i = 0; i < 16; i++) begin
            req_addr = 32'h8000 + 32'(i * 4);
            cyc;
        end
        req_valid = 0;
        cyc(2);
        chk("t6_sat", cnt_read, 15);
        chk("t6_occ", occupancy, 0);
        // reset with a stalled presented operation
        req_valid = 1; req_op = 2; req_addr = 32'hBEEF; bus_ready = 0;
        cyc;
        req_valid = 0;
        chk("t7_valid_pre", bus_valid, 1);
        reset = 1;
        cyc;
        chk("t7_valid", bus_valid, 0);
        chk("t7_occ", occupancy, 0);
        chk("t7_cr", cnt_read, 0);
        chk("t7_cw", cnt_write, 0);
        chk("t7_cm", cnt_modify, 0);
        chk("t7_ci", cnt_inval, 0);
        chk("t7_ready", req_ready, 0);
        reset = 0;
        cyc;
        chk("t7_ready_after", req_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_op_queue.md
Name: bus_op_queue

Overview:
- Parametrised successor to the L2 bus-operation functions.
- Instead of printing R/W/M/I operations the moment they are called, it buffers them in a FIFO and issues them on a valid/ready bus interface.
- Keeps per-operation saturating statistics counters and supports a queue flush.
- Sits between the L2 cache controller (producer) and the bus/memory model (consumer).

Parameters:
- ADDR_W, 32, address width in bits.
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  producer has an operation.
- req_ready  out  1  queue accepts an operation this cycle.
- req_op  in  2  operation code: 00=Read(R), 01=Write(W), 10=Modify(M), 11=Invalidate(I).
- req_addr  in  ADDR_W  operation address.
- flush  in  1  discard all queued, un-issued operations.
- bus_valid  out  1  head operation presented to the bus.
- bus_ready  in  1  bus accepts the head operation.
- bus_op  out  2  head operation code.
- bus_addr  out  ADDR_W  head operation address.
- occupancy  out  $clog2(DEPTH)+1  number of entries held, including the presented head.
- cnt_read  out  CNT_W  issued Read count.
- cnt_write  out  CNT_W  issued Write count.
- cnt_modify  out  CNT_W  issued Modify count.
- cnt_inval  out  CNT_W  issued Invalidate count.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: entries emptied, bus_valid=0, bus_op=0, bus_addr=0, occupancy=0, all four counters=0, req_ready=0 during the reset cycle. reset has priority over every other input.
- Push: occurs when req_valid && req_ready.
  - req_ready = !full && !flush && !reset, driven combinationally from registered state.
  - No bypass: when full, a simultaneous pop does not make room in the same cycle.
- Pop: occurs when bus_valid && bus_ready.
- Latency: an operation pushed into an empty queue in cycle N appears with bus_valid=1 in cycle N+1. Back-to-back pops sustain 1 operation per cycle.
- Ordering: strict FIFO. No reordering or merging of operations.
- Bus stability: while bus_valid && !bus_ready, bus_op and bus_addr stay stable and bus_valid stays high.
- Simultaneous push and pop when neither empty nor full: occupancy is unchanged.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from an occupancy counter, not from pointer equality alone.
- Counters:
  - On each pop, the counter selected by bus_op increments by 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Counters are cleared only by reset; flush does not clear them.
- Flush, asserted for one or more cycles:
  - All entries not yet handshaken are discarded at the edge.
  - Exception: if bus_valid && !bus_ready at that edge, the head entry is kept so the presented operation stays stable. Occupancy becomes 1 and the remaining entries are dropped.
  - If bus_valid && bus_ready at that edge, the head pops normally and is counted; occupancy becomes 0.
  - req_ready=0 while flush is high, so no push happens in a flush cycle.
- Reset mid-operation: a presented, un-accepted operation is dropped; bus_valid is low in the next cycle.
- Invalid op codes: none; all four 2-bit codes are legal.

Optional Feature:
- Macro: BUS_TRACE_EN.
- Defined: on each pop, the simulation trace writes one line in the existing bus-print format: the letter R/W/M/I, a space, then the address in hex (e.g. "R 0000a4c0"). Writes go through the file_write bus_display path; this is simulation-only code.
- Undefined: no trace output; the RTL is identical in every other respect.

Test Plan:
- Reset, then a single push of Read 0x0000A4C0 -> bus_valid=1 one cycle later with bus_op=00 and bus_addr=0x0000A4C0; with bus_ready=1, cnt_read=1 and occupancy returns to 0.
- Push W 0x100, M 0x200, I 0x300 with bus_ready=0, then raise bus_ready -> issued in order W, M, I on consecutive cycles; cnt_write=1, cnt_modify=1, cnt_inval=1.
- Push DEPTH=8 entries with bus_ready=0 -> occupancy=8 and req_ready=0; a push attempted in the same cycle as a pop is refused; req_ready=1 the cycle after the pop.
- With 5 entries queued and bus_ready=0, pulse flush -> occupancy=1 and the head address is unchanged; after the pop, occupancy=0 and the dropped entries never appear on the bus.
- Force cnt_read near saturation (CNT_W=4, 16 Read pops) -> cnt_read holds at 15.
- Assert reset while bus_valid=1 and bus_ready=0 -> next cycle bus_valid=0, occupancy=0, all counters=0.
